// File: rtl/mc8051_fetch_unit_if.sv
// Program-memory read port of the fetch unit: byte address/request out, ack/data back.
// The fetch unit drives the master side; the program memory answers on the slave side.
interface mc8051_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] o_rom_addr;
  logic                  o_rom_req;
  logic                  i_rom_ack;
  logic [7:0]            i_rom_data;

  modport master (
    output o_rom_addr,
    output o_rom_req,
    input  i_rom_ack,
    input  i_rom_data
  );

  modport slave (
    input  o_rom_addr,
    input  o_rom_req,
    output i_rom_ack,
    output i_rom_data
  );
endinterface

// File: rtl/mc8051_fetch_unit.sv
// 8051 fetch stage: owns the PC, reads 1-3 instruction bytes per req/ack and holds them for execute.
// Each byte costs one ack plus a one-cycle req gap; the buffer is held until i_exec_done.
module mc8051_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mc8051_fetch_unit_if.master   rom_if,
  output logic [7:0]            o_instr_buffer,
  output logic [7:0]            o_operand1,
  output logic [7:0]            o_operand2,
  output logic [1:0]            o_instr_len,
  output logic                  o_instr_valid,
  output logic [1:0]            o_multi_cycle_times,
  input  logic                  i_cycle_adv,
  input  logic                  i_exec_done,
  input  logic                  i_pc_load,
  input  logic [ADDR_WIDTH-1:0] i_pc_target,
  output logic [ADDR_WIDTH-1:0] o_pc
);

  typedef enum logic [1:0] {S_OP, S_B1, S_B2, S_EXEC} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  function automatic logic [1:0] f_len(input logic [7:0] op);
    if (op inside {8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63, 8'h75,
                   8'h85, 8'h90, [8'hB4:8'hBF], 8'hD5})
      return 2'd3;
    if (op[3:0] == 4'h1 ||
        op inside {8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42, 8'h44, 8'h45,
                   8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62, 8'h64, 8'h65, 8'h70, 8'h72,
                   8'h74, [8'h76:8'h7F], 8'h80, 8'h82, [8'h86:8'h8F], 8'h92, 8'h94, 8'h95,
                   8'hA0, 8'hA2, [8'hA6:8'hAF], 8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0,
                   8'hD2, [8'hD8:8'hDF], 8'hE5, 8'hF5})
      return 2'd2;
    return 2'd1;
  endfunction

  state_t                r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_ptr, w_ptr;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc;
  logic [7:0]            r_op, w_op, r_op1, w_op1, r_op2, w_op2;
  logic [1:0]            r_len, w_len, r_mct, w_mct;
  logic                  r_gap, w_gap;
  logic                  w_req, w_acc, w_fetch;
  logic [ADDR_WIDTH-1:0] w_ptr_inc;
  logic [1:0]            w_new_len;

  // r_gap forces the one idle request cycle after each accepted byte and out of reset.
  assign w_fetch   = (r_state != S_EXEC);
  assign w_req     = w_fetch && !r_gap;
  assign w_acc     = w_req && rom_if.i_rom_ack;
  assign w_ptr_inc = r_ptr + ONE;
  assign w_new_len = f_len(rom_if.i_rom_data);

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_pc    = r_pc;
    w_op    = r_op;
    w_op1   = r_op1;
    w_op2   = r_op2;
    w_len   = r_len;
    w_mct   = r_mct;
    w_gap   = 1'b0;
    case (r_state)
      S_OP: if (w_acc) begin
        w_op  = rom_if.i_rom_data;
        w_op1 = 8'h00;
        w_op2 = 8'h00;
        w_len = w_new_len;
        w_ptr = w_ptr_inc;
        if (w_new_len == 2'd1) begin
          w_state = S_EXEC;
          w_pc    = w_ptr_inc;
          w_mct   = 2'd0;
        end else begin
          w_state = S_B1;
          w_gap   = 1'b1;
        end
      end
      S_B1: if (w_acc) begin
        w_op1 = rom_if.i_rom_data;
        w_ptr = w_ptr_inc;
        if (r_len == 2'd2) begin
          w_state = S_EXEC;
          w_pc    = w_ptr_inc;
          w_mct   = 2'd0;
        end else begin
          w_state = S_B2;
          w_gap   = 1'b1;
        end
      end
      S_B2: if (w_acc) begin
        w_op2   = rom_if.i_rom_data;
        w_ptr   = w_ptr_inc;
        w_state = S_EXEC;
        w_pc    = w_ptr_inc;
        w_mct   = 2'd0;
      end
      default: begin
        if (i_exec_done) begin
          w_state = S_OP;
          w_mct   = 2'd0;
          if (i_pc_load) w_ptr = i_pc_target;
        end else if (i_cycle_adv && r_mct != 2'd3) begin
          w_mct = r_mct + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_OP;
      r_ptr   <= RESET_PC;
      r_pc    <= RESET_PC;
      r_op    <= 8'h00;
      r_op1   <= 8'h00;
      r_op2   <= 8'h00;
      r_len   <= 2'd1;
      r_mct   <= 2'd0;
      r_gap   <= 1'b1;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_pc    <= w_pc;
      r_op    <= w_op;
      r_op1   <= w_op1;
      r_op2   <= w_op2;
      r_len   <= w_len;
      r_mct   <= w_mct;
      r_gap   <= w_gap;
    end
  end

  assign rom_if.o_rom_addr   = r_ptr;
  assign rom_if.o_rom_req    = w_req;
  assign o_instr_buffer      = r_op;
  assign o_operand1          = r_op1;
  assign o_operand2          = r_op2;
  assign o_instr_len         = r_len;
  assign o_instr_valid       = (r_state == S_EXEC);
  assign o_multi_cycle_times = r_mct;
  assign o_pc                = r_pc;

endmodule

// File: tb/tb_mc8051_fetch_unit.sv
// Scoreboard bench for mc8051_fetch_unit: directed programs, a wait-state memory model,
// and a monitor that checks every accepted ROM request and every completed instruction.
module tb_mc8051_fetch_unit;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [1:0]  len;
    logic [15:0] pc;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  instr_buffer, operand1, operand2;
  logic [1:0]  instr_len, mct;
  logic        instr_valid;
  logic        cycle_adv, exec_done, pc_load;
  logic [15:0] pc_target, pc;

  mc8051_fetch_unit_if #(.ADDR_WIDTH(16)) rom_if ();

  mc8051_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .rom_if              (rom_if),
    .o_instr_buffer      (instr_buffer),
    .o_operand1          (operand1),
    .o_operand2          (operand2),
    .o_instr_len         (instr_len),
    .o_instr_valid       (instr_valid),
    .o_multi_cycle_times (mct),
    .i_cycle_adv         (cycle_adv),
    .i_exec_done         (exec_done),
    .i_pc_load           (pc_load),
    .i_pc_target         (pc_target),
    .o_pc                (pc)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  int          delay = 0;
  int          tests = 0;
  int          errors = 0;
  logic [15:0] exp_req[$];
  ins_t        exp_ins[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after `delay` idle request cycles, with data valid in the ack cycle.
  initial begin
    int wcnt;
    wcnt = 0;
    rom_if.i_rom_ack  = 1'b0;
    rom_if.i_rom_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rom_if.o_rom_req && !rom_if.i_rom_ack) begin
        if (wcnt >= delay) begin
          rom_if.i_rom_ack  = 1'b1;
          rom_if.i_rom_data = mem[rom_if.o_rom_addr];
        end else begin
          wcnt++;
        end
      end else begin
        rom_if.i_rom_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: request protocol, request addresses and completed instructions.
  initial begin
    logic        p_req, p_acc, p_val, acc;
    logic [15:0] p_addr, ea;
    ins_t        ei;
    p_req = 1'b0; p_acc = 1'b0; p_val = 1'b0; p_addr = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        p_req = 1'b0; p_acc = 1'b0; p_val = 1'b0;
        continue;
      end
      acc = rom_if.o_rom_req && rom_if.i_rom_ack;
      if (p_acc) begin
        chk("req_gap", {31'd0, rom_if.o_rom_req}, 32'd0);
      end else if (p_req) begin
        chk("req_hold", {31'd0, rom_if.o_rom_req}, 32'd1);
        chk("addr_hold", {16'd0, rom_if.o_rom_addr}, {16'd0, p_addr});
      end
      if (acc) begin
        if (exp_req.size() == 0) begin
          tests++; errors++;
          $display("FAIL unexpected_req: got addr %0h, expected none", rom_if.o_rom_addr);
        end else begin
          ea = exp_req.pop_front();
          chk("req_addr", {16'd0, rom_if.o_rom_addr}, {16'd0, ea});
        end
      end
      if (instr_valid && !p_val) begin
        if (exp_ins.size() == 0) begin
          tests++; errors++;
          $display("FAIL unexpected_instr: got op %0h, expected none", instr_buffer);
        end else begin
          ei = exp_ins.pop_front();
          chk("opcode", {24'd0, instr_buffer}, {24'd0, ei.op});
          chk("operand1", {24'd0, operand1}, {24'd0, ei.op1});
          chk("operand2", {24'd0, operand2}, {24'd0, ei.op2});
          chk("instr_len", {30'd0, instr_len}, {30'd0, ei.len});
          chk("o_pc", {16'd0, pc}, {16'd0, ei.pc});
          chk("mct_entry", {30'd0, mct}, 32'd0);
        end
      end
      p_req  = rom_if.o_rom_req;
      p_acc  = acc;
      p_addr = rom_if.o_rom_addr;
      p_val  = instr_valid;
    end
  end

  task automatic push_ins(input logic [7:0] op, input logic [7:0] op1, input logic [7:0] op2,
                          input logic [1:0] len, input logic [15:0] npc);
    ins_t t;
    t.op = op; t.op1 = op1; t.op2 = op2; t.len = len; t.pc = npc;
    exp_ins.push_back(t);
  endtask

  task automatic pulse(input logic d, input logic l, input logic a, input logic [15:0] tgt);
    @(negedge clk);
    #1;
    exec_done = d; pc_load = l; cycle_adv = a; pc_target = tgt;
    @(negedge clk);
    #1;
    exec_done = 1'b0; pc_load = 1'b0; cycle_adv = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (instr_valid) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no valid, expected valid within 200 cycles", name);
    end
  endtask

  task automatic wait_sig(input string name, input bit need_ack);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (rom_if.o_rom_req && (!need_ack || rom_if.i_rom_ack)) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no event, expected one within 200 cycles", name);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b1; cycle_adv = 1'b0; exec_done = 1'b0; pc_load = 1'b0; pc_target = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req", {31'd0, rom_if.o_rom_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_len", {30'd0, instr_len}, 32'd1);
    chk("rst_buf", {24'd0, instr_buffer}, 32'd0);
    chk("rst_op1", {24'd0, operand1}, 32'd0);
    chk("rst_op2", {24'd0, operand2}, 32'd0);
    chk("rst_mct", {30'd0, mct}, 32'd0);
    chk("rst_pc", {16'd0, pc}, 32'd0);

    // NOP out of reset with zero-wait memory
    exp_req.push_back(16'h0000);
    push_ins(8'h00, 8'h00, 8'h00, 2'd1, 16'h0001);
    @(negedge clk); #1 rst = 1'b0;
    wait_valid("nop");

    // LJMP 1234
    @(negedge clk); #1 rst = 1'b1;
    mem[16'h0000] = 8'h02; mem[16'h0001] = 8'h12; mem[16'h0002] = 8'h34;
    exp_req.push_back(16'h0000); exp_req.push_back(16'h0001); exp_req.push_back(16'h0002);
    push_ins(8'h02, 8'h12, 8'h34, 2'd3, 16'h0003);
    @(negedge clk); #1 rst = 1'b0;
    wait_valid("ljmp");

    // Branch to 1234: MOV A,#5A with three wait states; exec_done during fetch is ignored
    mem[16'h1234] = 8'h74; mem[16'h1235] = 8'h5A;
    delay = 3;
    exp_req.push_back(16'h1234); exp_req.push_back(16'h1235);
    push_ins(8'h74, 8'h5A, 8'h00, 2'd2, 16'h1236);
    pulse(1'b1, 1'b1, 1'b0, 16'h1234);
    chk("done_valid", {31'd0, instr_valid}, 32'd0);
    chk("done_mct", {30'd0, mct}, 32'd0);
    pulse(1'b1, 1'b1, 1'b0, 16'h4444);
    wait_valid("mov");

    // Machine-cycle counter saturates at 3
    for (int k = 0; k < 4; k++) begin
      pulse(1'b0, 1'b0, 1'b1, 16'h0000);
      chk("mct_adv", {30'd0, mct}, (k < 2) ? k + 1 : 3);
    end
    pulse(1'b0, 1'b1, 1'b0, 16'h5555);
    chk("load_no_done_valid", {31'd0, instr_valid}, 32'd1);

    // Done with cycle_adv: done wins; sequential fetch continues at 1236
    delay = 0;
    exp_req.push_back(16'h1236);
    push_ins(8'h00, 8'h00, 8'h00, 2'd1, 16'h1237);
    pulse(1'b1, 1'b0, 1'b1, 16'h0000);
    chk("done_adv_mct", {30'd0, mct}, 32'd0);
    chk("done_adv_valid", {31'd0, instr_valid}, 32'd0);
    wait_valid("seq");

    // Fetch pointer wraps FFFF -> 0000
    mem[16'hFFFF] = 8'h80; mem[16'h0000] = 8'hFE;
    exp_req.push_back(16'hFFFF); exp_req.push_back(16'h0000);
    push_ins(8'h80, 8'hFE, 8'h00, 2'd2, 16'h0001);
    pulse(1'b1, 1'b1, 1'b0, 16'hFFFF);
    wait_valid("wrap");

    // Reset while waiting on operand1
    mem[16'h0100] = 8'h74; mem[16'h0101] = 8'h11;
    delay = 5;
    exp_req.push_back(16'h0100);
    pulse(1'b1, 1'b1, 1'b0, 16'h0100);
    wait_sig("op_ack", 1'b1);
    wait_sig("b1_req", 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'd0, rom_if.o_rom_req}, 32'd0);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_buf", {24'd0, instr_buffer}, 32'd0);
    chk("midrst_pc", {16'd0, pc}, 32'd0);
    mem[16'h0000] = 8'h00;
    delay = 0;
    exp_req.push_back(16'h0000);
    push_ins(8'h00, 8'h00, 8'h00, 2'd1, 16'h0001);
    @(negedge clk); #1 rst = 1'b0;
    wait_valid("post_rst");

    repeat (3) @(negedge clk);
    chk("req_queue_left", exp_req.size(), 32'd0);
    chk("ins_queue_left", exp_ins.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
